tsc_param: RTL and testbench

TSC_PARAM -- requirements
Module: tsc_param

---
 rtl/tsc_param.sv | 230 +++++++++++++++++++++++
 tb/tb_tsc_param.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tsc_param.sv
// Triggered sample capture: circular ADC buffer with pre-trigger history and serial readout.
// Define TSC_EDGE_TRIG_EN for a rising-crossing trigger; the default is a level trigger.
`timescale 1ns/1ps

module tsc_param #(
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 16,
  parameter int                PRE_TRIG = 4,
  parameter logic [DATA_W-1:0] THRESH   = 8'hC0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              SBF,
  input  logic              rdy,
  input  logic [DATA_W-1:0] dat,
  output logic              req,
  output logic              TRD,
  output logic              CD,
  output logic              SD
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_W);

  localparam logic [CW-1:0] PRE_N     = CW'(PRE_TRIG);
  localparam logic [CW-1:0] POST_LAST = CW'(DEPTH - PRE_TRIG - 2);
  localparam logic [CW-1:0] DEPTH_N   = CW'(DEPTH);
  localparam logic [AW-1:0] PRE_OFF   = AW'(PRE_TRIG);
  localparam logic [BW-1:0] BIT_TOP   = BW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, ARM, POST, DONE, SEND} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     trig_addr_q, trig_addr_d;
  logic [CW-1:0]     pre_cnt_q, pre_cnt_d;
  logic [CW-1:0]     post_cnt_q, post_cnt_d;
  logic [CW-1:0]     word_cnt_q, word_cnt_d;
  logic [BW-1:0]     bit_idx_q, bit_idx_d;
  logic              trd_q, trd_d;
  logic              cd_q, cd_d;
  logic              sd_q, sd_d;
  logic              rdy_q, rdy_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic              acc;
  logic              hit;
  logic              wr_en;
  logic              clr;

`ifdef TSC_EDGE_TRIG_EN
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;

  function automatic logic trig_hit(input logic [DATA_W-1:0] cur,
                                    input logic [DATA_W-1:0] prev,
                                    input logic              prev_vld);
    return prev_vld && (prev < THRESH) && (cur >= THRESH);
  endfunction

  assign hit = trig_hit(dat, prev_q, prev_vld_q);
`else
  function automatic logic trig_hit(input logic [DATA_W-1:0] cur);
    return cur >= THRESH;
  endfunction

  assign hit = trig_hit(dat);
`endif

  // A sample is taken once per rdy rising edge, and only while capturing.
  assign acc     = ((state_q == ARM) || (state_q == POST)) && rdy && !rdy_q;
  assign rd_word = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    trig_addr_d = trig_addr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    word_cnt_d  = word_cnt_q;
    bit_idx_d   = bit_idx_q;
    trd_d       = trd_q;
    cd_d        = cd_q;
    sd_d        = 1'b0;
    rdy_d       = rdy;
    wr_en       = 1'b0;
    clr         = 1'b0;
`ifdef TSC_EDGE_TRIG_EN
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
          clr     = 1'b1;
        end
      end

      ARM: begin
        if (acc) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (pre_cnt_q < PRE_N) pre_cnt_d = pre_cnt_q + CW'(1);
`ifdef TSC_EDGE_TRIG_EN
          prev_d     = dat;
          prev_vld_d = 1'b1;
`endif
          // Armed only once PRE_TRIG samples precede this one, so the window is full.
          if ((pre_cnt_q == PRE_N) && hit) begin
            state_d     = POST;
            trd_d       = 1'b1;
            trig_addr_d = wr_ptr_q;
            post_cnt_d  = '0;
          end
        end
      end

      POST: begin
        if (acc) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (post_cnt_q == POST_LAST) begin
            state_d = DONE;
            cd_d    = 1'b1;
          end else begin
            post_cnt_d = post_cnt_q + CW'(1);
          end
        end
      end

      DONE: begin
        if (SBF) begin
          state_d    = SEND;
          rd_ptr_d   = trig_addr_q - PRE_OFF;
          bit_idx_d  = BIT_TOP;
          word_cnt_d = '0;
        end else if (start) begin
          state_d = ARM;
          clr     = 1'b1;
        end
      end

      SEND: begin
        // One extra cycle after the last word lets SD show the final bit while still in SEND.
        if (word_cnt_q == DEPTH_N) begin
          state_d = IDLE;
          cd_d    = 1'b0;
        end else begin
          sd_d = rd_word[bit_idx_q];
          if (bit_idx_q == '0) begin
            bit_idx_d  = BIT_TOP;
            rd_ptr_d   = rd_ptr_q + AW'(1);
            word_cnt_d = word_cnt_q + CW'(1);
          end else begin
            bit_idx_d = bit_idx_q - BW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (clr) begin
      wr_ptr_d   = '0;
      pre_cnt_d  = '0;
      post_cnt_d = '0;
      trd_d      = 1'b0;
      cd_d       = 1'b0;
`ifdef TSC_EDGE_TRIG_EN
      prev_vld_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
      word_cnt_q <= '0;
      bit_idx_q  <= '0;
      trd_q      <= 1'b0;
      cd_q       <= 1'b0;
      sd_q       <= 1'b0;
      rdy_q      <= 1'b0;
`ifdef TSC_EDGE_TRIG_EN
      prev_vld_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      word_cnt_q <= word_cnt_d;
      bit_idx_q  <= bit_idx_d;
      trd_q      <= trd_d;
      cd_q       <= cd_d;
      sd_q       <= sd_d;
      rdy_q      <= rdy_d;
`ifdef TSC_EDGE_TRIG_EN
      prev_vld_q <= prev_vld_d;
`endif
    end
  end

  // Sample storage and trigger address carry data only and are left out of reset.
  always_ff @(posedge clk) begin
    trig_addr_q <= trig_addr_d;
`ifdef TSC_EDGE_TRIG_EN
    prev_q      <= prev_d;
`endif
    if (wr_en) mem_q[wr_ptr_q] <= dat;
  end

  assign req = (state_q == ARM) || (state_q == POST);
  assign TRD = trd_q;
  assign CD  = cd_q;
  assign SD  = sd_q;

endmodule

// File: tb/tb_tsc_param.sv
// Directed self-checking bench for tsc_param at default parameters.
`timescale 1ns/1ps

module tb_tsc_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       SBF = 1'b0;
  logic       rdy = 1'b0;
  logic [7:0] dat = 8'h00;
  logic       req, TRD, CD, SD;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tsc_param #(
    .DATA_W(8), .DEPTH(16), .PRE_TRIG(4), .THRESH(8'hC0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .SBF(SBF), .rdy(rdy), .dat(dat),
    .req(req), .TRD(TRD), .CD(CD), .SD(SD)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; SBF = 1'b0; rdy = 1'b0; dat = 8'h00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic put(input logic [7:0] v);
    dat = v; rdy = 1'b1;
    tick();
    rdy = 1'b0;
    tick();
  endtask

  // 00,01,02,03,D0 then 05..0F: trigger on D0, 11 post samples -> DONE.
  task automatic simple_capture();
    go();
    for (int i = 0; i < 16; i++) put((i == 4) ? 8'hD0 : 8'(i));
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", req); end
    checks++; if (TRD !== 1'b0) begin errors++; $display("FAIL reset_trd got=%b exp=0", TRD); end
    checks++; if (CD  !== 1'b0) begin errors++; $display("FAIL reset_cd got=%b exp=0", CD); end
    checks++; if (SD  !== 1'b0) begin errors++; $display("FAIL reset_sd got=%b exp=0", SD); end
  endtask

  task automatic test_capture();
    logic [7:0] cap [18] = '{8'h00, 8'h0A, 8'h99, 8'h9B, 8'h93, 8'hD5, 8'h97, 8'h90, 8'h9F,
                             8'hD7, 8'h8D, 8'h9C, 8'h85, 8'h8A, 8'h91, 8'h8C, 8'h00, 8'h00};
    do_reset();
    go();
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL cap_req_arm got=%b exp=1", req); end
    for (int i = 0; i < 18; i++) begin
      put(cap[i]);
      checks++;
      if (TRD !== (i >= 5)) begin
        errors++; $display("FAIL cap_trd[%0d] got=%b exp=%b", i, TRD, (i >= 5));
      end
      checks++;
      if (CD !== (i >= 16)) begin
        errors++; $display("FAIL cap_cd[%0d] got=%b exp=%b", i, CD, (i >= 16));
      end
      checks++;
      if (req !== (i < 16)) begin
        errors++; $display("FAIL cap_req[%0d] got=%b exp=%b", i, req, (i < 16));
      end
    end
  endtask

  task automatic test_send();
    logic [7:0] win [16] = '{8'h0A, 8'h99, 8'h9B, 8'h93, 8'hD5, 8'h97, 8'h90, 8'h9F,
                             8'hD7, 8'h8D, 8'h9C, 8'h85, 8'h8A, 8'h91, 8'h8C, 8'h00};
    logic [7:0] word;
    SBF = 1'b1;
    tick();
    SBF = 1'b0;
    checks++; if (SD !== 1'b0) begin errors++; $display("FAIL send_first_cycle_sd got=%b exp=0", SD); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL send_req got=%b exp=0", req); end
    tick();
    for (int w = 0; w < 16; w++) begin
      word = 8'h00;
      for (int b = 0; b < 8; b++) begin
        word = {word[6:0], SD};
        if (w == 15 && b == 7) begin
          checks++;
          if (CD !== 1'b1) begin errors++; $display("FAIL send_cd_last_bit got=%b exp=1", CD); end
        end
        tick();
      end
      checks++;
      if (word !== win[w]) begin
        errors++; $display("FAIL send_word[%0d] got=%h exp=%h", w, word, win[w]);
      end
    end
    checks++; if (CD  !== 1'b0) begin errors++; $display("FAIL send_end_cd got=%b exp=0", CD); end
    checks++; if (SD  !== 1'b0) begin errors++; $display("FAIL send_end_sd got=%b exp=0", SD); end
    checks++; if (TRD !== 1'b1) begin errors++; $display("FAIL send_end_trd got=%b exp=1", TRD); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL send_end_req got=%b exp=0", req); end
  endtask

  task automatic test_pretrig();
    logic [7:0] v [5] = '{8'hD5, 8'h11, 8'h22, 8'h33, 8'hD7};
    do_reset();
    go();
    for (int i = 0; i < 5; i++) begin
      put(v[i]);
      checks++;
      if (TRD !== (i == 4)) begin
        errors++; $display("FAIL pretrig_trd[%0d] got=%b exp=%b", i, TRD, (i == 4));
      end
    end
  endtask

  task automatic test_trigger_mode();
    logic [7:0] v [7] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'h10, 8'hC6};
    int first;
`ifdef TSC_EDGE_TRIG_EN
    first = 6;
`else
    first = 4;
`endif
    do_reset();
    go();
    for (int i = 0; i < 7; i++) begin
      put(v[i]);
      checks++;
      if (TRD !== (i >= first)) begin
        errors++; $display("FAIL mode_trd[%0d] got=%b exp=%b", i, TRD, (i >= first));
      end
    end
  endtask

  task automatic test_threshold();
    do_reset();
    go();
    for (int i = 0; i < 4; i++) put(8'h00);
    put(8'hBF);
    checks++; if (TRD !== 1'b0) begin errors++; $display("FAIL thresh_below got=%b exp=0", TRD); end
    put(8'hC0);
    checks++; if (TRD !== 1'b1) begin errors++; $display("FAIL thresh_equal got=%b exp=1", TRD); end
  endtask

  task automatic test_reset_post();
    do_reset();
    go();
    put(8'h00); put(8'h01); put(8'h02); put(8'h03); put(8'hD0);
    put(8'h05);
    checks++; if (TRD !== 1'b1) begin errors++; $display("FAIL rpost_pre_trd got=%b exp=1", TRD); end
    reset = 1'b1; start = 1'b1; rdy = 1'b1; dat = 8'hD0;
    tick();
    reset = 1'b0; start = 1'b0; rdy = 1'b0;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rpost_req got=%b exp=0", req); end
    checks++; if (TRD !== 1'b0) begin errors++; $display("FAIL rpost_trd got=%b exp=0", TRD); end
    checks++; if (CD  !== 1'b0) begin errors++; $display("FAIL rpost_cd got=%b exp=0", CD); end
    checks++; if (SD  !== 1'b0) begin errors++; $display("FAIL rpost_sd got=%b exp=0", SD); end
    put(8'hD0); put(8'hE0);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rpost_idle_req got=%b exp=0", req); end
    checks++; if (TRD !== 1'b0) begin errors++; $display("FAIL rpost_idle_trd got=%b exp=0", TRD); end
    go();
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL rpost_restart_req got=%b exp=1", req); end
  endtask

  task automatic test_reset_send();
    do_reset();
    simple_capture();
    checks++; if (CD !== 1'b1) begin errors++; $display("FAIL rsend_cd got=%b exp=1", CD); end
    SBF = 1'b1;
    tick();
    SBF = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    checks++; if (SD !== 1'b1) begin errors++; $display("FAIL rsend_bit15 got=%b exp=1", SD); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (SD  !== 1'b0) begin errors++; $display("FAIL rsend_sd got=%b exp=0", SD); end
    checks++; if (CD  !== 1'b0) begin errors++; $display("FAIL rsend_cd_after got=%b exp=0", CD); end
    checks++; if (TRD !== 1'b0) begin errors++; $display("FAIL rsend_trd got=%b exp=0", TRD); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rsend_req got=%b exp=0", req); end
    tick();
    checks++; if (SD  !== 1'b0) begin errors++; $display("FAIL rsend_sd_idle got=%b exp=0", SD); end
  endtask

  task automatic test_rdy_hold();
    do_reset();
    go();
    SBF = 1'b1;
    tick();
    SBF = 1'b0;
    tick();
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL sbf_arm_req got=%b exp=1", req); end
    checks++; if (SD  !== 1'b0) begin errors++; $display("FAIL sbf_arm_sd got=%b exp=0", SD); end
    dat = 8'h10; rdy = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rdy = 1'b0;
    tick();
    put(8'h11); put(8'h12);
    put(8'hD0);
    checks++; if (TRD !== 1'b0) begin errors++; $display("FAIL hold_not_armed got=%b exp=0", TRD); end
    put(8'hD1);
    checks++; if (TRD !== 1'b1) begin errors++; $display("FAIL hold_armed got=%b exp=1", TRD); end
  endtask

  task automatic test_done_cmds();
    do_reset();
    simple_capture();
    start = 1'b1; SBF = 1'b1;
    tick();
    start = 1'b0; SBF = 1'b0;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL both_req got=%b exp=0", req); end
    checks++; if (CD  !== 1'b1) begin errors++; $display("FAIL both_cd got=%b exp=1", CD); end
    do_reset();
    simple_capture();
    checks++; if (TRD !== 1'b1) begin errors++; $display("FAIL restart_pre_trd got=%b exp=1", TRD); end
    go();
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL restart_req got=%b exp=1", req); end
    checks++; if (CD  !== 1'b0) begin errors++; $display("FAIL restart_cd got=%b exp=0", CD); end
    checks++; if (TRD !== 1'b0) begin errors++; $display("FAIL restart_trd got=%b exp=0", TRD); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_send();
    test_pretrig();
    test_trigger_mode();
    test_threshold();
    test_reset_post();
    test_reset_send();
    test_rdy_hold();
    test_done_cmds();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
